seq_tx_1010: RTL and testbench
==============================

Name: seq_tx_1010

Overview:
- Transmit-side counterpart to the overlapping 1010 sequence detector.
- Accepts a parallel payload word over a valid/ready handshake.
- Serializes the word MSB-first behind a 4-bit 1010 sync preamble, then inserts idle gap cycles.
- Drives the serial line that feeds the detector's x input. A downstream detector sees exactly one preamble hit per frame plus any hits inside the payload.

Parameters:
- DATA_W, 8, payload width in bits (legal 1..32).
- PREAMBLE, 4'b1010, sync pattern, sent MSB-first.
- GAP, 2, idle cycles (x=0, x_valid=0) after each frame (legal 0..15).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- din  input  DATA_W  payload word.
- din_valid  input  1  payload offered.
- din_ready  output  1  block can accept payload this cycle.
- x  output  1  serial bit out (registered).
- x_valid  output  1  x carries a preamble, data or parity bit (registered).
- busy  output  1  frame in progress (any state other than IDLE).
- frame_done  output  1  one-cycle pulse coincident with the last bit of a frame (registered).

Behaviour:
- Reset values: state=IDLE, x=0, x_valid=0, frame_done=0, shift register=0, counters=0.
- din_ready = (state==IDLE) && !reset. It is combinational from state only, with no dependence on din_valid.
- busy = (state!=IDLE).
- States: IDLE, PRE, DATA, PAR (only with the optional feature), GAP.
- IDLE: on din_valid&&din_ready at edge N, capture din, go to PRE. PREAMBLE[3] appears on x with x_valid=1 during cycle N+1. If din_valid is low, stay in IDLE with x=0, x_valid=0.
- PRE: 4 cycles, emitting PREAMBLE[3..0]. On the last one, go to DATA.
- DATA: DATA_W cycles, emitting captured din[DATA_W-1..0], MSB first. On the last bit:
  - with parity: go to PAR;
  - else if GAP>0: go to GAP;
  - else: go to IDLE.
- GAP: GAP cycles with x=0, x_valid=0, then IDLE. The first accept after a frame occurs at the edge that enters IDLE + 0 cycles, i.e. din_ready is high in the first IDLE cycle.
- Latency and frame length:
  - Accept to first bit: 1 cycle.
  - Frame length: 4+DATA_W(+1) valid cycles.
  - Accept-to-accept minimum period: 4+DATA_W(+1)+GAP+1 cycles.
- frame_done is high exactly in the cycle x carries the final bit of the frame: the last data bit, or the parity bit when parity is enabled.
- din and din_valid changes while busy are ignored. The captured word is stable for the whole frame.
- Bit counter width is $clog2(DATA_W+1). Counters never wrap mid-state; each resets to 0 on state entry.
- Reset mid-frame: immediate abort. x and x_valid drop to 0 asynchronously, no frame_done pulse, and the next frame starts with a full preamble.
- Payload bits are sent verbatim with no stuffing. Payload-embedded 1010 patterns are the receiver's concern.

Optional Feature:
- Macro SEQ_TX_PARITY_EN.
- Defined: PAR state appends one even-parity bit (XOR of captured din) after the data bits, with x_valid=1. frame_done moves to the parity cycle. Frame grows by 1 cycle.
- Undefined: no PAR state, no parity logic. DATA goes straight to GAP or IDLE.

Decomposition:
- Package seq_pkg holds:
  - the state enum (IDLE, PRE, DATA, PAR, GAP);
  - the PREAMBLE_1010 constant (4'b1010);
  - the PRE_W=4 localparam.
  These are shared with the detector and its bench.
- One natural sub-module: seq_piso. It is a parameterized parallel-load, MSB-first shift register with a load enable, a shift enable and a serial output. It is instantiated once for the payload. Preamble bits are indexed directly from the constant.

Test Plan:
1. Reset with no traffic: assert reset, release, din_valid=0 for 20 cycles -> x=0, x_valid=0, busy=0, din_ready=1 throughout.
2. Single frame din=8'h5A, GAP=2, no parity -> x_valid high 12 cycles carrying 1010_01011010. frame_done is high on cycle 12 only, then 2 gap cycles, then din_ready=1.
3. Back-to-back frames 8'hFF then 8'h00 with din_valid held high -> second accept is exactly 15 cycles after the first. Streams are 1010_11111111 and 1010_00000000, and din changes during busy do not leak into the output.
4. Reset asserted on the 3rd data bit of din=8'hA5 -> x and x_valid are 0 immediately, with no frame_done. The next frame, 8'h3C, is emitted in full: 1010_00111100.
5. With SEQ_TX_PARITY_EN, din=8'h07 -> stream 1010_00000111_1. frame_done is on the parity cycle and the frame is 13 valid cycles.
6. Loopback into the 1010 overlapping detector, din=8'h0A -> detector z pulses once at the preamble end and once at the payload's trailing 1010, for 2 hits total.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the 1010 sync-sequence transmitter and detector.
// Holds the frame state encoding, the sync preamble and its width.
package seq_pkg;

    // Frame states; S_PAR is only reachable when parity is built in.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_DATA = 3'd2,
        S_PAR  = 3'd3,
        S_GAP  = 3'd4
    } seq_state_e;

    localparam int         PRE_W         = 4;
    localparam logic [3:0] PREAMBLE_1010 = 4'b1010;

endpackage

// File: rtl/seq_piso.sv
// Parallel-load, MSB-first shift register with a single serial output.
// Load wins over shift; the vacated LSB fills with zero.
module seq_piso #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         sout
);

    logic [W-1:0] shreg;

    // Capture the payload on load, otherwise move the next bit into the MSB.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg <= '0;
        end else if (load) begin
            shreg <= din;
        end else if (shift) begin
            shreg <= shreg << 1;
        end
    end

    assign sout = shreg[W-1];

endmodule

// File: rtl/seq_tx_1010.sv
// Framed serial transmitter: 1010 preamble, MSB-first payload, idle gap.
// Optional trailing even-parity bit is built when SEQ_TX_PARITY_EN is defined.
// All serial outputs are registered and cleared asynchronously by reset.
module seq_tx_1010
    import seq_pkg::*;
#(
    parameter int              DATA_W   = 8,
    parameter logic [PRE_W-1:0] PREAMBLE = PREAMBLE_1010,
    parameter int              GAP      = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              x,
    output logic              x_valid,
    output logic              busy,
    output logic              frame_done
);

    localparam int               BIT_W    = $clog2(DATA_W + 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
    localparam logic [1:0]       LAST_PRE = 2'(PRE_W - 1);
    localparam logic [3:0]       LAST_GAP = 4'(GAP - 1);

    seq_state_e       state, state_n;
    logic [1:0]       pre_cnt, pre_cnt_n;
    logic [BIT_W-1:0] bit_cnt, bit_cnt_n;
    logic [3:0]       gap_cnt, gap_cnt_n;
    logic             load, shift;
    logic             piso_out;
    logic             x_n, x_valid_n, frame_done_n;

`ifdef SEQ_TX_PARITY_EN
    logic             par_q;
`endif

    assign din_ready = (state == S_IDLE) && !reset;
    assign busy      = (state != S_IDLE);

    // Payload shifter; x takes its MSB at the same edge the register advances.
    seq_piso #(
        .W(DATA_W)
    ) u_piso (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .shift (shift),
        .din   (din),
        .sout  (piso_out)
    );

`ifdef SEQ_TX_PARITY_EN
    // Even parity of the word is fixed at accept time so the shifter can consume the word freely.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            par_q <= 1'b0;
        end else if (load) begin
            par_q <= ^din;
        end
    end
`endif

    // Next state and counters; each counter restarts at zero on every state entry.
    always_comb begin
        state_n   = state;
        pre_cnt_n = '0;
        bit_cnt_n = '0;
        gap_cnt_n = '0;
        load      = 1'b0;
        case (state)
            S_IDLE: begin
                if (din_valid && din_ready) begin
                    state_n = S_PRE;
                    load    = 1'b1;
                end
            end
            S_PRE: begin
                if (pre_cnt == LAST_PRE) begin
                    state_n = S_DATA;
                end else begin
                    pre_cnt_n = pre_cnt + 2'd1;
                end
            end
            S_DATA: begin
                if (bit_cnt == LAST_BIT) begin
`ifdef SEQ_TX_PARITY_EN
                    state_n = S_PAR;
`else
                    state_n = (GAP > 0) ? S_GAP : S_IDLE;
`endif
                end else begin
                    bit_cnt_n = bit_cnt + 1'b1;
                end
            end
`ifdef SEQ_TX_PARITY_EN
            S_PAR: begin
                state_n = (GAP > 0) ? S_GAP : S_IDLE;
            end
`endif
            S_GAP: begin
                if (gap_cnt == LAST_GAP) begin
                    state_n = S_IDLE;
                end else begin
                    gap_cnt_n = gap_cnt + 4'd1;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Output values for the coming cycle, derived from where the FSM is heading.
    always_comb begin
        x_n          = 1'b0;
        x_valid_n    = 1'b0;
        frame_done_n = 1'b0;
        shift        = 1'b0;
        case (state_n)
            S_PRE: begin
                x_n       = PREAMBLE[LAST_PRE - pre_cnt_n];
                x_valid_n = 1'b1;
            end
            S_DATA: begin
                x_n       = piso_out;
                x_valid_n = 1'b1;
                shift     = 1'b1;
`ifndef SEQ_TX_PARITY_EN
                frame_done_n = (bit_cnt_n == LAST_BIT);
`endif
            end
`ifdef SEQ_TX_PARITY_EN
            S_PAR: begin
                x_n          = par_q;
                x_valid_n    = 1'b1;
                frame_done_n = 1'b1;
            end
`endif
            default: begin
                x_n = 1'b0;
            end
        endcase
    end

    // State, counters and registered serial outputs; reset aborts any frame at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            pre_cnt    <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            x          <= 1'b0;
            x_valid    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            pre_cnt    <= pre_cnt_n;
            bit_cnt    <= bit_cnt_n;
            gap_cnt    <= gap_cnt_n;
            x          <= x_n;
            x_valid    <= x_valid_n;
            frame_done <= frame_done_n;
        end
    end

endmodule

// File: tb/tb_seq_tx_1010.sv
// Scoreboard bench for seq_tx_1010: stimulus queues expected serial bits,
// a negedge monitor pops and compares them whenever x_valid is high.
// Expectations follow SEQ_TX_PARITY_EN when it is defined.
module tb_seq_tx_1010;

    localparam int DATA_W = 8;
    localparam int GAP    = 2;
`ifdef SEQ_TX_PARITY_EN
    localparam int PAR_EN = 1;
`else
    localparam int PAR_EN = 0;
`endif
    localparam int FRAME_BITS = 4 + DATA_W + PAR_EN;
    localparam int PERIOD     = FRAME_BITS + GAP + 1;

    typedef struct packed {
        logic x;
        logic fd;
    } exp_t;

    logic              clk;
    logic              reset;
    logic [DATA_W-1:0] din;
    logic              din_valid;
    logic              din_ready;
    logic              x;
    logic              x_valid;
    logic              busy;
    logic              frame_done;

    exp_t expQ[$];
    int   compCount  = 0;
    int   failCount  = 0;
    int   cycleCnt   = 0;
    int   lastAccept = 0;
    int   hits       = 0;
    int   validCnt   = 0;
    logic [3:0] hist = 4'b0000;

    seq_tx_1010 #(
        .DATA_W (DATA_W),
        .GAP    (GAP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .x          (x),
        .x_valid    (x_valid),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Expected serial stream of one frame: preamble, payload MSB first, optional parity.
    task automatic pushFrame(input logic [DATA_W-1:0] word);
        logic [3:0] pre;
        exp_t e;
        pre = 4'b1010;
        for (int i = 3; i >= 0; i--) begin
            e.x  = pre[i];
            e.fd = 1'b0;
            expQ.push_back(e);
        end
        for (int i = DATA_W - 1; i >= 0; i--) begin
            e.x  = word[i];
            e.fd = (i == 0) && (PAR_EN == 0);
            expQ.push_back(e);
        end
        if (PAR_EN != 0) begin
            e.x  = ^word;
            e.fd = 1'b1;
            expQ.push_back(e);
        end
    endtask

    // Offer a word as soon as the DUT is ready; junk on din while waiting must not leak.
    task automatic applyStimulus(input logic [DATA_W-1:0] word, input bit hold);
        int waitCnt;
        waitCnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (din_ready) break;
            din = DATA_W'($urandom);
            waitCnt++;
            if (waitCnt > 100) begin
                checkOutput("ready_timeout", 32'(din_ready), 32'd1);
                return;
            end
        end
        din        = word;
        din_valid  = 1'b1;
        lastAccept = cycleCnt;
        pushFrame(word);
        @(posedge clk);
        #1;
        checkOutput("first_bit_latency", 32'({x_valid, x, busy}), 32'b111);
        if (!hold) din_valid = 1'b0;
        din = DATA_W'($urandom);
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || expQ.size() != 0) && n < 200);
        if (n >= 200) checkOutput("idle_timeout", 32'(busy), 32'd0);
        checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
    endtask

    // Monitor: compare every valid serial bit against the scoreboard and feed a 1010 detector model.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset) begin
            if (x_valid) begin
                validCnt++;
                hist = {hist[2:0], x};
                if (hist == 4'b1010) hits++;
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_bit", 32'd1, 32'd0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("serial_bit", 32'(x), 32'(e.x));
                    checkOutput("frame_done_on_bit", 32'(frame_done), 32'(e.fd));
                end
            end else if (frame_done) begin
                checkOutput("frame_done_without_valid", 32'(frame_done), 32'd0);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int a1;
        int hitsBefore;
        int validBefore;

        reset     = 1'b1;
        din       = '0;
        din_valid = 1'b0;

        // Reset with no traffic.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("ready_in_reset", 32'(din_ready), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkOutput("idle_outputs", 32'({x, x_valid, busy, din_ready}), 32'b0001);
        end

        // Single frame and its gap.
        $display("[TB] single frame 5A");
        validBefore = validCnt;
        applyStimulus(8'h5A, 1'b0);
        begin
            int n;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!frame_done && n < 50);
            checkOutput("frame_done_seen", 32'(frame_done), 32'd1);
        end
        for (int g = 0; g < GAP; g++) begin
            @(negedge clk);
            checkOutput("gap_cycle", 32'({x_valid, busy, din_ready}), 32'b010);
        end
        @(negedge clk);
        checkOutput("ready_after_gap", 32'({busy, din_ready}), 32'b01);
        checkOutput("frame_length_5A", 32'(validCnt - validBefore), 32'(FRAME_BITS));
        waitIdle();

        // Back-to-back frames with din_valid held high.
        $display("[TB] back-to-back FF then 00");
        applyStimulus(8'hFF, 1'b1);
        a1 = lastAccept;
        applyStimulus(8'h00, 1'b1);
        din_valid = 1'b0;
        checkOutput("accept_period", 32'(lastAccept - a1), 32'(PERIOD));
        waitIdle();

        // Reset on the third data bit, then a full frame.
        $display("[TB] abort A5 then 3C");
        applyStimulus(8'hA5, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        checkOutput("third_data_bit", 32'({x_valid, x}), 32'b11);
        reset = 1'b1;
        #1;
        checkOutput("abort_outputs", 32'({x, x_valid, frame_done, busy}), 32'b0000);
        checkOutput("abort_leftover", 32'(expQ.size()), 32'(FRAME_BITS - 6));
        expQ.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        applyStimulus(8'h3C, 1'b0);
        waitIdle();

        // Word with three set bits: odd parity content when parity is built in.
        $display("[TB] frame 07");
        validBefore = validCnt;
        applyStimulus(8'h07, 1'b0);
        waitIdle();
        checkOutput("frame_length_07", 32'(validCnt - validBefore), 32'(FRAME_BITS));

        // Loopback into the overlapping 1010 detector model.
        $display("[TB] loopback 0A");
        hitsBefore = hits;
        applyStimulus(8'h0A, 1'b0);
        waitIdle();
        checkOutput("loopback_hits", 32'(hits - hitsBefore), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, failCount);
        $finish;
    end

endmodule
